// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared FSM/grant types, operand widths and grant priority for the VRAM arbiter.
package vram_arb_pkg;
   localparam int ADDR_W       = 23;
   localparam int DATA_W       = 32;
   localparam int SIZE_W       = 2;
   localparam int BUSY_TIMEOUT = 4;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_DONE} state_t;
   typedef enum logic [1:0] {GNT_NONE, GNT_REF, GNT_A, GNT_B} gnt_t;

   // Refresh always first; a starved B pre-empts A, otherwise A beats B.
   function automatic gnt_t select_grant(input logic ref_p, input logic a, input logic b, input logic starved);
      return ref_p ? GNT_REF : starved ? GNT_B : a ? GNT_A : b ? GNT_B : GNT_NONE;
   endfunction
endpackage

// File: rtl/vram_arbiter_refresh_timer.sv
// refresh_timer: free-running refresh interval counter with pending request and sticky overrun flag.
module refresh_timer #(
   parameter int INTERVAL = 840
) (
   input  logic clk,
   input  logic reset,
   input  logic pending_clr,
   output logic pending,
   output logic overrun
);
   localparam int CW = (INTERVAL < 2) ? 1 : $clog2(INTERVAL);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          pending_q, pending_d;
   logic          overrun_q, overrun_d;
   logic          wrap;

   assign wrap = cnt_q == CW'(INTERVAL - 1);

   // A wrap always re-arms pending, even when the current refresh is issued in the same cycle.
   always_comb begin
      cnt_d     = wrap ? '0 : cnt_q + 1'b1;
      pending_d = wrap | (pending_q & ~pending_clr);
      overrun_d = overrun_q | (wrap & pending_q & ~pending_clr);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   assign pending = pending_q;
   assign overrun = overrun_q;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: arbitrates refresh and two request ports onto a single memory-controller command interface.
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int REFRESH_INTERVAL = 840,
   parameter int STARVE_LIMIT     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_read,
   input  logic              a_write,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_din32,
   input  logic [SIZE_W-1:0] a_wr_size,
   input  logic              b_read,
   input  logic              b_write,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_din32,
   input  logic [SIZE_W-1:0] b_wr_size,
   output logic              a_ack,
   output logic              b_ack,
   output logic              mem_read,
   output logic              mem_write,
   output logic              mem_refresh,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din32,
   output logic [SIZE_W-1:0] mem_wr_size,
   input  logic              mem_busy,
   output logic              refresh_overrun
);
   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   state_t            state_q, state_d;
   gnt_t              gnt_q, gnt_d, grant;
   logic [1:0]        wb_cnt_q, wb_cnt_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [SIZE_W-1:0] size_q, size_d;
   logic              rd_q, rd_d, wr_q, wr_d, rf_q, rf_d;
   logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
   logic              a_req, b_req, starved, refresh_pending, pending_clr;

   assign a_req   = a_read | a_write;
   assign b_req   = b_read | b_write;
   assign starved = b_req && (starve_q == SW'(STARVE_LIMIT));

   refresh_timer #(.INTERVAL(REFRESH_INTERVAL)) u_refresh (
      .clk        (clk),
      .reset      (reset),
      .pending_clr(pending_clr),
      .pending    (refresh_pending),
      .overrun    (refresh_overrun)
   );

   // No grant while an ack is out: a port still holds its request in that cycle.
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      wb_cnt_d = wb_cnt_q;
      grant    = GNT_NONE;
      a_ack_d  = 1'b0;
      b_ack_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            grant = (mem_busy || a_ack_q || b_ack_q) ? GNT_NONE : select_grant(refresh_pending, a_req, b_req, starved);
            if (grant != GNT_NONE) begin
               state_d  = ST_ISSUE;
               gnt_d    = grant;
               wb_cnt_d = '0;
            end
         end
         ST_ISSUE: state_d = ST_WAIT_BUSY;
         ST_WAIT_BUSY: begin
            wb_cnt_d = wb_cnt_q + 2'd1;
            if (mem_busy || wb_cnt_q == 2'(BUSY_TIMEOUT - 1)) state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (!mem_busy) begin
               state_d = ST_IDLE;
               a_ack_d = gnt_q == GNT_A;
               b_ack_d = gnt_q == GNT_B;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Operands latch only on a port grant; write wins when a port raises both read and write.
   always_comb begin
      pending_clr = grant == GNT_REF;
      rf_d        = pending_clr;
      wr_d        = (grant == GNT_A) ? a_write : (grant == GNT_B) ? b_write : 1'b0;
      rd_d        = (grant == GNT_A && !a_write) || (grant == GNT_B && !b_write);
      addr_d      = (grant == GNT_A) ? a_addr : (grant == GNT_B) ? b_addr : addr_q;
      din_d       = (grant == GNT_A) ? a_din32 : (grant == GNT_B) ? b_din32 : din_q;
      size_d      = (grant == GNT_A) ? a_wr_size : (grant == GNT_B) ? b_wr_size : size_q;
      starve_d    = (grant == GNT_B || !b_req) ? '0 :
                    (grant == GNT_A && starve_q != SW'(STARVE_LIMIT)) ? starve_q + 1'b1 : starve_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         gnt_q    <= GNT_NONE;
         wb_cnt_q <= '0;
         starve_q <= '0;
         addr_q   <= '0;
         din_q    <= '0;
         size_q   <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         rf_q     <= 1'b0;
         a_ack_q  <= 1'b0;
         b_ack_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         wb_cnt_q <= wb_cnt_d;
         starve_q <= starve_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         size_q   <= size_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         rf_q     <= rf_d;
         a_ack_q  <= a_ack_d;
         b_ack_q  <= b_ack_d;
      end
   end

   assign mem_read    = rd_q;
   assign mem_write   = wr_q;
   assign mem_refresh = rf_q;
   assign mem_addr    = addr_q;
   assign mem_din32   = din_q;
   assign mem_wr_size = size_q;
   assign a_ack       = a_ack_q;
   assign b_ack       = b_ack_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: vector table, directed corner sequences and a randomized scoreboard run for vram_arbiter.
module tb_vram_arbiter;
   localparam int RI = 16;
   localparam int SL = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        a_read, a_write, b_read, b_write;
   logic [22:0] a_addr, b_addr;
   logic [31:0] a_din32, b_din32;
   logic [1:0]  a_wr_size, b_wr_size;
   logic        a_ack, b_ack, mem_read, mem_write, mem_refresh, mem_busy, refresh_overrun;
   logic [22:0] mem_addr;
   logic [31:0] mem_din32;
   logic [1:0]  mem_wr_size;

   int   tests = 0;
   int   fails = 0;
   int   ctl_k = 1;
   bit   ctl_rand = 1'b0;
   logic ctl_busy = 1'b0;
   logic force_busy = 1'b0;
   int   busy_left = 0;
   int   start_len = 0;

   assign mem_busy = ctl_busy | force_busy;

   always #5 clk = ~clk;

   vram_arbiter #(.REFRESH_INTERVAL(RI), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .reset(reset),
      .a_read(a_read), .a_write(a_write), .a_addr(a_addr), .a_din32(a_din32), .a_wr_size(a_wr_size),
      .b_read(b_read), .b_write(b_write), .b_addr(b_addr), .b_din32(b_din32), .b_wr_size(b_wr_size),
      .a_ack(a_ack), .b_ack(b_ack),
      .mem_read(mem_read), .mem_write(mem_write), .mem_refresh(mem_refresh),
      .mem_addr(mem_addr), .mem_din32(mem_din32), .mem_wr_size(mem_wr_size),
      .mem_busy(mem_busy), .refresh_overrun(refresh_overrun)
   );

   // Memory controller model: busy rises the cycle after a command and stays high for the chosen length.
   always @(negedge clk or posedge reset) begin
      if (reset) begin
         ctl_busy  <= 1'b0;
         busy_left <= 0;
         start_len <= 0;
      end else begin
         if (start_len > 0) begin
            ctl_busy  <= 1'b1;
            busy_left <= start_len - 1;
         end else if (busy_left > 0) begin
            ctl_busy  <= 1'b1;
            busy_left <= busy_left - 1;
         end else ctl_busy <= 1'b0;
         start_len <= (mem_read | mem_write | mem_refresh) ? (ctl_rand ? int'($urandom_range(4)) : ctl_k) : 0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_ports();
      a_read = 0; a_write = 0; a_addr = '0; a_din32 = '0; a_wr_size = '0;
      b_read = 0; b_write = 0; b_addr = '0; b_din32 = '0; b_wr_size = '0;
   endtask

   task automatic do_reset();
      clear_ports();
      force_busy = 0;
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
   endtask

   typedef struct {
      logic        ar, aw;
      logic [22:0] aa;
      logic        br, bw;
      logic [22:0] ba;
      int          k;
      logic        exp_wr;
      logic [22:0] exp_addr;
      logic        exp_b;
      int          exp_lat;
   } vec_t;

   vec_t vecs[8];
   int   exp_seq[10];
   int   got[10];

   initial begin
      int ack_at, nstb, n, nref, last, nack, starve, inflight, age, m;
      logic ar, br, win_b, found;
      // latency = 3 + busy length, or 7 when busy never rises (4-cycle busy timeout)
      vecs[0] = '{1, 0, 23'h123456, 0, 0, 23'h000000, 3, 0, 23'h123456, 0, 6};
      vecs[1] = '{0, 1, 23'h7FFFFF, 0, 0, 23'h000000, 1, 1, 23'h7FFFFF, 0, 4};
      vecs[2] = '{1, 1, 23'h000AAA, 0, 0, 23'h000000, 2, 1, 23'h000AAA, 0, 5};
      vecs[3] = '{0, 0, 23'h000000, 1, 1, 23'h000100, 1, 1, 23'h000100, 1, 4};
      vecs[4] = '{1, 0, 23'h0000F0, 0, 1, 23'h0000F1, 1, 0, 23'h0000F0, 0, 4};
      vecs[5] = '{0, 0, 23'h000000, 1, 0, 23'h400000, 0, 0, 23'h400000, 1, 7};
      vecs[6] = '{0, 0, 23'h000000, 0, 1, 23'h2BCDEF, 4, 1, 23'h2BCDEF, 1, 7};
      vecs[7] = '{0, 1, 23'h000000, 1, 0, 23'h000777, 1, 1, 23'h000000, 0, 4};
      exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

      clear_ports();
      @(negedge clk);
      chk("reset_strobes", {mem_read, mem_write, mem_refresh}, 0);
      chk("reset_acks", {a_ack, b_ack}, 0);
      chk("reset_overrun", refresh_overrun, 0);
      chk("reset_operands", {mem_addr, mem_din32, mem_wr_size}, 0);
      reset = 0;

      for (int i = 0; i < 8; i++) begin
         do_reset();
         ctl_rand = 0;
         ctl_k = vecs[i].k;
         a_read = vecs[i].ar; a_write = vecs[i].aw; a_addr = vecs[i].aa;
         a_din32 = {9'h0A5, vecs[i].aa}; a_wr_size = 2'd1;
         b_read = vecs[i].br; b_write = vecs[i].bw; b_addr = vecs[i].ba;
         b_din32 = {9'h15B, vecs[i].ba}; b_wr_size = 2'd2;
         ack_at = -1;
         nstb = 0;
         for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (mem_read | mem_write) begin
               nstb++;
               if (nstb == 1) begin
                  chk($sformatf("v%0d_write", i), mem_write, vecs[i].exp_wr);
                  chk($sformatf("v%0d_read", i), mem_read, !vecs[i].exp_wr);
                  chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].exp_addr);
                  if (vecs[i].exp_wr) begin
                     chk($sformatf("v%0d_din", i), mem_din32, vecs[i].exp_b ? {9'h15B, vecs[i].exp_addr} : {9'h0A5, vecs[i].exp_addr});
                     chk($sformatf("v%0d_size", i), mem_wr_size, vecs[i].exp_b ? 2'd2 : 2'd1);
                  end
               end
            end
            if ((a_ack | b_ack) && ack_at < 0) begin
               ack_at = c;
               chk($sformatf("v%0d_ack_b", i), b_ack, vecs[i].exp_b);
               chk($sformatf("v%0d_ack_a", i), a_ack, !vecs[i].exp_b);
               clear_ports();
            end
         end
         chk($sformatf("v%0d_latency", i), ack_at, vecs[i].exp_lat);
         chk($sformatf("v%0d_strobes", i), nstb, 1);
      end

      // A and B held continuously: B gets every fifth port grant
      do_reset();
      ctl_k = 1;
      a_read = 1; a_addr = 23'h11;
      b_read = 1; b_addr = 23'h22;
      n = 0;
      for (int c = 0; c < 300 && n < 10; c++) begin
         @(negedge clk);
         if (mem_read) begin
            got[n] = (mem_addr == 23'h22) ? 1 : 0;
            n++;
         end
      end
      for (int i = 0; i < 10; i++) chk($sformatf("starve_seq%0d", i), (i < n) ? got[i] : 2, exp_seq[i]);

      // Idle ports: one refresh every RI cycles
      do_reset();
      ctl_k = 1;
      nref = 0;
      last = -1;
      for (int c = 1; c <= 90; c++) begin
         @(negedge clk);
         if (mem_refresh) begin
            if (last >= 0) chk("ref_period", c - last, RI);
            last = c;
            nref++;
         end
      end
      chk("ref_count", nref, 5);
      chk("ref_no_overrun", refresh_overrun, 0);

      // Busy stuck high for 40 cycles: overrun, then exactly one refresh
      do_reset();
      force_busy = 1;
      nref = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         nref += int'(mem_refresh);
      end
      chk("ovr_none_while_busy", nref, 0);
      chk("ovr_flag", refresh_overrun, 1);
      force_busy = 0;
      ctl_k = 1;
      nref = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         nref += int'(mem_refresh);
      end
      chk("ovr_one_refresh", nref, 1);
      chk("ovr_sticky", refresh_overrun, 1);

      // Reset during WAIT_DONE of an A write
      do_reset();
      ctl_k = 5;
      a_write = 1; a_addr = 23'h55; a_din32 = 32'hDEADBEEF; a_wr_size = 2'd3;
      found = 0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         found = mem_write;
      end
      chk("rst_strobe_seen", found, 1);
      @(negedge clk);
      @(negedge clk);
      reset = 1;
      clear_ports();
      #1;
      chk("rst_mid_flags", {mem_read, mem_write, mem_refresh, a_ack, b_ack, refresh_overrun}, 0);
      chk("rst_mid_operands", {mem_addr, mem_din32, mem_wr_size}, 0);
      @(negedge clk);
      reset = 0;
      nack = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         nack += int'(a_ack);
      end
      chk("rst_no_ack", nack, 0);

      // Request dropped right after its command: still acked once, never restarted
      do_reset();
      ctl_k = 2;
      a_read = 1; a_addr = 23'h66;
      found = 0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         found = mem_read;
      end
      chk("drop_strobe_seen", found, 1);
      clear_ports();
      nack = 0;
      nstb = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         nack += int'(a_ack);
         nstb += int'(mem_read | mem_write);
      end
      chk("drop_ack", nack, 1);
      chk("drop_no_restart", nstb, 0);

      // Randomized traffic against a transaction-level model of the grant rules
      do_reset();
      ctl_rand = 1;
      starve = 0;
      inflight = 0;
      age = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         ar = a_read | a_write;
         br = b_read | b_write;
         if (mem_read | mem_write) begin
            chk("rnd_onehot", int'(mem_read) + int'(mem_write) + int'(mem_refresh), 1);
            chk("rnd_no_overlap", inflight, 0);
            chk("rnd_has_requester", ar | br, 1);
            win_b = br && (starve == SL || !ar);
            chk("rnd_addr", mem_addr, win_b ? b_addr : a_addr);
            chk("rnd_write", mem_write, win_b ? b_write : a_write);
            if (mem_write) begin
               chk("rnd_din", mem_din32, win_b ? b_din32 : a_din32);
               chk("rnd_size", mem_wr_size, win_b ? b_wr_size : a_wr_size);
            end
            starve = win_b ? 0 : (br ? ((starve < SL) ? starve + 1 : SL) : starve);
            inflight = win_b ? 2 : 1;
            age = 0;
         end
         if (a_ack) begin
            chk("rnd_ack_a", inflight, 1);
            inflight = 0;
            a_read = 0; a_write = 0;
         end
         if (b_ack) begin
            chk("rnd_ack_b", inflight, 2);
            inflight = 0;
            b_read = 0; b_write = 0;
         end
         if (inflight != 0) begin
            age++;
            if (age > 40) begin
               chk("rnd_ack_timeout", age, 40);
               inflight = 0;
            end
         end
         if (!(a_read | a_write) && $urandom_range(2) == 0) begin
            m = int'($urandom_range(2));
            a_read = m != 1; a_write = m != 0;
            a_addr = 23'($urandom); a_din32 = $urandom; a_wr_size = 2'($urandom);
         end
         if (!(b_read | b_write) && $urandom_range(2) == 0) begin
            m = int'($urandom_range(2));
            b_read = m != 1; b_write = m != 0;
            b_addr = 23'($urandom); b_din32 = $urandom; b_wr_size = 2'($urandom);
         end
         if (!(b_read | b_write)) starve = 0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter REFRESH_INTERVAL, default 840; clk cycles between refresh requests (7.8 us at 108 MHz).
REQ-002 Parameter STARVE_LIMIT, default 4; consecutive port-A grants allowed while port B waits.
REQ-003 Port clk  in  1  memory-side clock (clk_sdramp domain); only clock.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port a_read, a_write  in  1 each  port A (VDP) requests; level, held until a_ack.
REQ-006 Port a_addr  in  23  port A address; a_din32 in 32; a_wr_size in 2.
REQ-007 Port b_read, b_write  in  1 each  port B (secondary fetch/blit) requests; level, held until b_ack.
REQ-008 Port b_addr  in  23; b_din32 in 32; b_wr_size in 2.
REQ-009 Port a_ack, b_ack  out  1  one-cycle completion pulse; read data valid on mem_dout32 in the same cycle.
REQ-010 Port mem_read, mem_write, mem_refresh  out  1  one-cycle command strobes to the memory controller.
REQ-011 Port mem_addr out 23; mem_din32 out 32; mem_wr_size out 2; command operands, registered.
REQ-012 Port mem_busy  in  1  controller busy flag.
REQ-013 Port refresh_overrun  out  1  sticky flag; interval expired while refresh still pending.

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-015 IDLE with mem_busy low: select winner by priority refresh-pending > A > B; latch operands; go to ISSUE.
REQ-016 Starvation: if B requesting and starve_cnt == STARVE_LIMIT, B beats A (refresh still first).
REQ-017 starve_cnt increments on each A grant while B requests, clears on any B grant or when B idle; saturates at STARVE_LIMIT.
REQ-018 ISSUE: assert exactly one of mem_read/mem_write/mem_refresh for one cycle; go to WAIT_BUSY.
REQ-019 WAIT_BUSY: on mem_busy high go to WAIT_DONE; if mem_busy still low after 4 cycles, go to WAIT_DONE anyway.
REQ-020 WAIT_DONE: on mem_busy low pulse the granted port's ack (none for refresh); return to IDLE.
REQ-021 Minimum request-to-ack latency: 4 cycles (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE with a 1-cycle busy).
REQ-022 Read and write both asserted on one port: write wins.
REQ-023 Refresh timer: counts 0..REFRESH_INTERVAL-1, wraps; on wrap sets refresh_pending.
REQ-024 refresh_pending clears on refresh issue.
REQ-025 Timer wrap while refresh_pending already set: set refresh_overrun; no extra refresh queued.
REQ-026 Timer wrap in the same cycle as refresh issue: pending remains set (new interval).
REQ-027 Request dropped before ack: the transaction in flight completes; ack still pulses; no new transaction is started for that port.
REQ-028 Never more than one command strobe per transaction; never a strobe outside ISSUE.

Reset
REQ-029 reset asserted: FSM=IDLE; all strobes, acks, refresh_overrun=0; mem_addr/mem_din32/mem_wr_size=0; timer=0; refresh_pending=0; starve_cnt=0.
REQ-030 Reset mid-transaction: abandon immediately; no ack after release.

Structure
REQ-031 FSM state enum and grant enum (GNT_NONE, GNT_REF, GNT_A, GNT_B) live in shared package vram_arb_pkg.
REQ-032 Refresh timer is sub-module refresh_timer (clk, reset, pending_clr -> pending, overrun).
REQ-033 Port mux and starvation counter stay in vram_arbiter.

Verification
REQ-034 A read only, busy 3 cycles: mem_read one pulse with a_addr; a_ack 1 cycle after busy falls.
REQ-035 A and B held continuously, STARVE_LIMIT=4: grant sequence A,A,A,A,B,A,A,A,A,B.
REQ-036 REFRESH_INTERVAL=16, idle ports: mem_refresh every 16 cycles; refresh_overrun stays 0.
REQ-037 Busy held high for 40 cycles, REFRESH_INTERVAL=16: refresh_overrun=1; exactly one refresh issued after busy falls.
REQ-038 reset pulsed during WAIT_DONE of A write: outputs 0 next cycle; no a_ack after release.
REQ-039 B asserts read+write at 0x000100: only mem_write issued, mem_addr=0x000100.
